// File: rtl/whack_game_ctrl.sv
// whack_game_ctrl: reaction-game sequencer. One random lane is lit per round; a clean
// press of that lane scores, a wrong press or a timeout costs a life.
// Latency: start -> GEN on the next edge; lamp lit two cycles after GEN if buttons are idle.
// Backpressure: none; a button still held from the last round stalls the round in ARM.
// Ports: clk, rst (sync, active-low), start, buttons[NUM_CH] in;
//        lights[NUM_CH], score[4], lives[4], busy, done, won out (all from registered state).
module whack_game_ctrl #(
    parameter int          NUM_CH      = 4,
    parameter int          TIMEOUT     = 50000000,
    parameter int          WIN_POINTS  = 10,
    parameter int          START_LIVES = 3,
    parameter int          NO_REPEAT   = 1,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NUM_CH-1:0] buttons,
    output logic [NUM_CH-1:0] lights,
    output logic [3:0]        score,
    output logic [3:0]        lives,
    output logic              busy,
    output logic              done,
    output logic              won
);

    localparam int             IW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int             TW      = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0]  T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [IW:0]    NC_EXT  = (IW + 1)'(NUM_CH);
    localparam logic [IW-1:0]  NC_LO   = IW'(NUM_CH);
    localparam logic [IW-1:0]  LAST_CH = IW'(NUM_CH - 1);
    localparam logic [3:0]     WIN     = 4'(WIN_POINTS);
    localparam logic [3:0]     LIVES0  = 4'(START_LIVES);

    typedef enum logic [2:0] {
        IDLE, GEN, ARM, WAIT, HIT, MISS, FINISH
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [15:0]       lfsr;
    logic [NUM_CH-1:0] btn_q;
    logic [IW-1:0]     target;
    logic [TW-1:0]     timer;

    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] tgt_mask;
    logic              tgt_rise;
    logic              wrong_rise;
    logic              lfsr_fb;
    logic [IW-1:0]     rnd;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     gen_tgt;
    logic [3:0]        score_inc;
    logic [3:0]        lives_dec;
    logic              restart;

    // Taps 16,14,13,11 (bits 15,13,12,10), shifting toward the MSB.
    assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // Only rising edges count, so a level held across cycles is a single press.
    assign rise       = buttons & ~btn_q;
    assign tgt_mask   = NUM_CH'(1) << target;
    assign tgt_rise   = |(rise & tgt_mask);
    assign wrong_rise = |(rise & ~tgt_mask);

    // Saturating counters: score never passes the win mark, lives never wrap.
    assign score_inc  = (score >= WIN) ? score : score + 4'd1;
    assign lives_dec  = (lives == 4'd0) ? 4'd0 : lives - 4'd1;
    assign restart    = ((state == IDLE) || (state == FINISH)) && start;

    // Fold the raw LFSR bits into 0..NUM_CH-1; the top half of the range for a
    // non-power-of-two lane count maps back by one subtraction.
    always_comb begin
        rnd     = lfsr[IW-1:0];
        idx     = rnd;
        gen_tgt = rnd;
        if ({1'b0, rnd} >= NC_EXT) begin
            idx = rnd - NC_LO;
        end
        gen_tgt = idx;
        if ((NO_REPEAT != 0) && (idx == target)) begin
            gen_tgt = (idx == LAST_CH) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, FINISH: if (start) state_nx = GEN;
            GEN:          state_nx = ARM;
            ARM:          if (buttons == '0) state_nx = WAIT;
            WAIT: begin
                // A stray lane poisons the round even if the target rose too.
                if (wrong_rise) begin
                    state_nx = MISS;
                end else if (tgt_rise) begin
                    state_nx = HIT;
                end else if (timer == T_LAST) begin
                    state_nx = MISS;
                end
            end
            HIT:          state_nx = (score_inc == WIN) ? FINISH : GEN;
            MISS:         state_nx = (lives_dec == 4'd0) ? FINISH : GEN;
            default:      state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr   <= LFSR_SEED;
            btn_q  <= '0;
            target <= '0;
            timer  <= '0;
            score  <= '0;
            lives  <= LIVES0;
            won    <= 1'b0;
        end else begin
            lfsr  <= {lfsr[14:0], lfsr_fb};
            btn_q <= buttons;
            // Held at zero outside WAIT, so every WAIT starts from a clean count.
            timer <= (state == WAIT) ? timer + 1'b1 : '0;
            if (restart) begin
                score <= '0;
                lives <= LIVES0;
                won   <= 1'b0;
            end
            if (state == GEN) begin
                target <= gen_tgt;
            end
            if (state == HIT) begin
                score <= score_inc;
                if (score_inc == WIN) begin
                    won <= 1'b1;
                end
            end
            if (state == MISS) begin
                lives <= lives_dec;
            end
        end
    end

    assign lights = (state == WAIT) ? tgt_mask : '0;
    assign busy   = (state == GEN) || (state == ARM) || (state == WAIT) ||
                    (state == HIT) || (state == MISS);
    assign done   = (state == FINISH);

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Bench for whack_game_ctrl with 4 lanes, 8-cycle rounds, 3 points to win, 2 lives.
// Directed scenarios followed by randomized rounds, scored against a game-level model.
module tb_whack_game_ctrl;

    localparam int          NCH  = 4;
    localparam int          TO   = 8;
    localparam int          WP   = 3;
    localparam int          SL   = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] buttons;
    logic [3:0] lights;
    logic [3:0] score;
    logic [3:0] lives;
    logic       busy;
    logic       done;
    logic       won;

    whack_game_ctrl #(
        .NUM_CH(NCH), .TIMEOUT(TO), .WIN_POINTS(WP), .START_LIVES(SL),
        .NO_REPEAT(1), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .buttons(buttons),
        .lights(lights), .score(score), .lives(lives),
        .busy(busy), .done(done), .won(won)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    int          m_score;
    int          m_lives;
    bit          m_done;
    bit          m_won;
    int          m_prev;
    logic [3:0]  last_obs;
    logic [3:0]  seen;
    logic [15:0] m_lfsr;
    logic [15:0] h1;
    logic [15:0] h2;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    // Free-running random source model; h2 holds the value from two cycles back.
    always @(posedge clk) begin
        if (!rst) m_lfsr <= SEED;
        else      m_lfsr <= lfsr_step(m_lfsr);
        h1 <= m_lfsr;
        h2 <= h1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected finish before 500us");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".score"},  32'(score),  32'(m_score));
        chk({tag, ".lives"},  32'(lives),  32'(m_lives));
        chk({tag, ".done"},   32'(done),   32'(m_done));
        chk({tag, ".won"},    32'(won),    32'(m_won));
        chk({tag, ".busy"},   32'(busy),   32'(!m_done));
        chk({tag, ".lights"}, 32'(lights), 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".lights"}, 32'(lights), 32'd0);
        chk({tag, ".score"},  32'(score),  32'd0);
        chk({tag, ".lives"},  32'(lives),  32'(SL));
        chk({tag, ".busy"},   32'(busy),   32'd0);
        chk({tag, ".done"},   32'(done),   32'd0);
        chk({tag, ".won"},    32'(won),    32'd0);
    endtask

    task automatic model_hit();
        if (m_score < WP) m_score++;
        if (m_score == WP) begin m_done = 1'b1; m_won = 1'b1; end
    endtask

    task automatic model_miss();
        if (m_lives > 0) m_lives--;
        if (m_lives == 0) begin m_done = 1'b1; m_won = 1'b0; end
    endtask

    // Target rule: low log2(NCH) bits, folded into range, bumped on a repeat.
    task automatic next_target(input logic [15:0] l, output int t);
        int r;
        r = int'(l) % (1 << $clog2(NCH));
        if (r >= NCH) r = r - NCH;
        if (r == m_prev) r = (r + 1) % NCH;
        m_prev = r;
        t = r;
    endtask

    task automatic model_reset();
        m_score = 0; m_lives = SL; m_done = 1'b0; m_won = 1'b0;
        m_prev = 0; last_obs = 4'd0;
    endtask

    // Call at a GEN/ARM negedge; returns at the first WAIT negedge.
    task automatic await_target(input bit use_h2, input logic [15:0] gl, output logic [3:0] tgt);
        bit found;
        int t;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (lights !== 4'd0) begin found = 1'b1; break; end
            @(negedge clk);
        end
        n_chk++;
        assert (found) n_pass++;
        else $error("FAIL await_lamp: observed %0h expected a lit lane", lights);
        next_target(use_h2 ? h2 : gl, t);
        tgt = 4'b0001 << t;
        chk("target", 32'(lights), 32'(tgt));
        chk("norepeat", 32'(lights == last_obs), 32'd0);
        last_obs = lights;
        seen = seen | lights;
    endtask

    task automatic start_game(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_score = 0; m_lives = SL; m_done = 1'b0; m_won = 1'b0;
        chk_state(tag);
    endtask

    task automatic round_hit(input logic [3:0] tgt, input string tag);
        int d;
        d = $urandom_range(0, TO - 1);
        start = 1'($urandom_range(0, 1));
        repeat (d) @(negedge clk);
        start = 1'b0;
        buttons = tgt;
        @(negedge clk);
        buttons = 4'd0;
        model_hit();
        @(negedge clk);
        chk_state(tag);
    endtask

    task automatic round_timeout(input logic [3:0] tgt, input string tag);
        repeat (TO - 1) @(negedge clk);
        chk({tag, ".last_wait"}, 32'(lights), 32'(tgt));
        @(negedge clk);
        chk({tag, ".miss_dark"}, 32'(lights), 32'd0);
        chk({tag, ".miss_busy"}, 32'(busy), 32'd1);
        model_miss();
        @(negedge clk);
        chk_state(tag);
    endtask

    task automatic round_wrong(input logic [3:0] tgt, input bit with_tgt, input string tag);
        int d;
        logic [3:0] other;
        d = $urandom_range(0, TO - 1);
        other = {tgt[2:0], tgt[3]} | (4'($urandom) & ~tgt);
        repeat (d) @(negedge clk);
        buttons = other | (with_tgt ? tgt : 4'd0);
        @(negedge clk);
        buttons = 4'd0;
        model_miss();
        @(negedge clk);
        chk_state(tag);
    endtask

    initial begin
        logic [3:0]  tgt;
        logic [15:0] gl;
        int          kind;

        rst = 1'b0; start = 1'b0; buttons = 4'd0; seen = 4'd0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b1;
        @(negedge clk);

        // Start pulse, first round, then a clean three-point win.
        start_game("start");
        await_target(1'b1, 16'd0, tgt);
        round_hit(tgt, "hit1");
        await_target(1'b1, 16'd0, tgt);
        round_hit(tgt, "hit2");
        await_target(1'b1, 16'd0, tgt);
        round_hit(tgt, "hit3");

        // Two timeouts lose the game; restart reloads lives.
        start_game("restart1");
        await_target(1'b1, 16'd0, tgt);
        round_timeout(tgt, "to1");
        await_target(1'b1, 16'd0, tgt);
        round_timeout(tgt, "to2");
        start_game("restart2");

        // Target and a wrong lane together is a miss.
        await_target(1'b1, 16'd0, tgt);
        round_hit(tgt, "hit4");
        await_target(1'b1, 16'd0, tgt);
        round_wrong(tgt, 1'b1, "both");

        // Button held into the next round: dark ARM until release, no score.
        await_target(1'b1, 16'd0, tgt);
        buttons = tgt;
        @(negedge clk);
        model_hit();
        @(negedge clk);
        gl = m_lfsr;
        chk_state("held_gen");
        repeat (6) begin
            @(negedge clk);
            chk("held_dark", 32'(lights), 32'd0);
            chk("held_busy", 32'(busy), 32'd1);
        end
        buttons = 4'd0;
        await_target(1'b0, gl, tgt);
        round_timeout(tgt, "held_nohit");

        // Reset in the middle of a round, together with a press.
        start_game("g4");
        await_target(1'b1, 16'd0, tgt);
        buttons = tgt | {tgt[2:0], tgt[3]};
        rst = 1'b0;
        @(negedge clk);
        chk_reset("midreset");
        buttons = 4'd0;
        rst = 1'b1;
        model_reset();
        @(negedge clk);

        // Randomized rounds.
        start_game("rnd_first");
        for (int r = 0; r < 200; r++) begin
            await_target(1'b1, 16'd0, tgt);
            kind = $urandom_range(0, 2);
            case (kind)
                0:       round_hit(tgt, "rnd_hit");
                1:       round_timeout(tgt, "rnd_to");
                default: round_wrong(tgt, 1'($urandom_range(0, 1)), "rnd_wrong");
            endcase
            if (m_done) start_game("rnd_start");
        end
        chk("all_lanes", 32'(seen), 32'hF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
